// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types and constants for the tile register-bus arbiter.
// The optional read timeout is enabled by defining REG_BUS_TIMEOUT_EN.
package reg_bus_arbiter_pkg;

    // Number of components on the register bus; comp ids at or above this are rejected.
    localparam int ID_LAST    = 8;
    localparam int COMP_IDX_W = $clog2(ID_LAST);

    typedef logic [31:0] reg_data_t;

    // One single-beat register access as presented by a requester.
    typedef struct packed {
        logic      write;
        logic [7:0] comp;
        logic [7:0] addr;
        reg_data_t wdata;
    } reg_bus_req_t;

    // Data returned when a read times out or the component id is out of range.
    localparam reg_data_t REG_BUS_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_AR,
        ST_RWAIT,
        ST_RESP
    } arb_state_t;

    localparam logic [7:0] COMP_LIMIT = 8'(ID_LAST);

    function automatic logic comp_in_range(input logic [7:0] comp);
        return comp < COMP_LIMIT;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_rr_arb.sv
// Rotating-priority one-hot grant for N_REQ requesters. The search starts at
// the pointer and wraps; the pointer moves past the winner only when the
// grant is actually accepted, so a held request is served within N_REQ-1
// other transactions.
module reg_bus_rr_arb #(
    parameter int N_REQ = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic                     accept,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     grant_any
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;

    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return IDX_W'(sum);
    endfunction

    // Pick the first valid requester at or after the pointer.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = rot_idx(ptr_q, k);
            if (!grant_any && req_valid[cand]) begin
                grant_any   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    // Advance the pointer to the requester after the accepted winner.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rstn) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares a tile's component register bus between N_REQ requesters, one
// single-beat 32b read or write at a time, with round-robin fairness.
// Define REG_BUS_TIMEOUT_EN to bound the read wait to TIMEOUT_CYCLES cycles,
// after which an error response carrying TIMEOUT_DATA is returned.
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int        N_REQ          = 2,
    parameter int        TIMEOUT_CYCLES = 1024,
    parameter reg_data_t TIMEOUT_DATA   = REG_BUS_TIMEOUT_DATA
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  reg_bus_req_t [N_REQ-1:0]      req,
    output logic [N_REQ-1:0]              resp_valid,
    input  logic [N_REQ-1:0]              resp_ready,
    output reg_data_t                     resp_data,
    output logic                          resp_err,
    output logic [15:0]                   reg_bus_waddr,
    output reg_data_t                     reg_bus_wdata,
    output logic [ID_LAST-1:0]            reg_bus_wvalid,
    output logic [ID_LAST-1:0]            reg_bus_arvalid,
    output logic [15:0]                   reg_bus_araddr,
    input  logic [ID_LAST-1:0]            reg_bus_rvalid,
    input  reg_data_t [ID_LAST-1:0]       reg_bus_rdata
);
    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("reg_bus_arbiter: N_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t              state_q, state_d;
    logic [N_REQ-1:0]        grant_q, grant_d;
    logic [COMP_IDX_W-1:0]   comp_q, comp_d;
    logic [7:0]              addr_q, addr_d;
    reg_data_t               wdata_q, wdata_d;
    reg_data_t               data_q, data_d;
    logic                    err_q, err_d;

    logic [N_REQ-1:0]        grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_any;
    logic                    accept;
    reg_bus_req_t            sel_req;
    logic                    sel_bad;
    logic                    resp_hs;
    logic                    rd_return;
    logic [ID_LAST-1:0]      comp_onehot;

`ifdef REG_BUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                    tmo_expired;
    assign tmo_expired = (tmo_cnt_q == TMO_LAST);
`endif

    assign accept      = (state_q == ST_IDLE) && grant_any;
    assign sel_req     = req[grant_idx];
    assign sel_bad     = !comp_in_range(sel_req.comp);
    assign resp_hs     = |(resp_ready & grant_q);
    assign rd_return   = reg_bus_rvalid[comp_q];
    assign comp_onehot = {{(ID_LAST-1){1'b0}}, 1'b1} << comp_q;

    reg_bus_rr_arb #(
        .N_REQ (N_REQ)
    ) u_rr_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // State register; reset aborts any transaction in flight without a response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: one transaction at a time, IDLE -> strobe -> (wait) -> RESP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    if (sel_bad)            state_d = ST_RESP;
                    else if (sel_req.write) state_d = ST_WR;
                    else                    state_d = ST_AR;
                end
            end
            ST_WR:    state_d = ST_RESP;
            ST_AR:    state_d = ST_RWAIT;
            ST_RWAIT: begin
                if (rd_return) state_d = ST_RESP;
`ifdef REG_BUS_TIMEOUT_EN
                else if (tmo_expired) state_d = ST_RESP;
`endif
            end
            ST_RESP:  if (resp_hs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: capture the winning request, then the response payload.
    always_comb begin
        grant_d = grant_q;
        comp_d  = comp_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef REG_BUS_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    grant_d = grant;
                    comp_d  = sel_req.comp[COMP_IDX_W-1:0];
                    addr_d  = sel_req.addr;
                    wdata_d = sel_req.wdata;
                    data_d  = sel_bad ? TIMEOUT_DATA : '0;
                    err_d   = sel_bad;
                end
            end
`ifdef REG_BUS_TIMEOUT_EN
            ST_AR: tmo_cnt_d = '0;
`endif
            ST_RWAIT: begin
                if (rd_return) begin
                    data_d = reg_bus_rdata[comp_q];
                    err_d  = 1'b0;
                end
`ifdef REG_BUS_TIMEOUT_EN
                else if (tmo_expired) begin
                    data_d = TIMEOUT_DATA;
                    err_d  = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    // Datapath registers; all cleared so every bus output reads 0 in reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_q <= '0;
            comp_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            grant_q <= grant_d;
            comp_q  <= comp_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

`ifdef REG_BUS_TIMEOUT_EN
    // Read-wait cycle counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    // Outputs decoded from state; strobes are single-cycle because WR/AR last one cycle.
    always_comb begin
        req_ready       = (state_q == ST_IDLE) ? grant : '0;
        resp_valid      = (state_q == ST_RESP) ? grant_q : '0;
        resp_data       = (state_q == ST_RESP) ? data_q : '0;
        resp_err        = (state_q == ST_RESP) && err_q;
        reg_bus_waddr   = {8'b0, addr_q};
        reg_bus_araddr  = {8'b0, addr_q};
        reg_bus_wdata   = wdata_q;
        reg_bus_wvalid  = (state_q == ST_WR) ? comp_onehot : '0;
        reg_bus_arvalid = (state_q == ST_AR) ? comp_onehot : '0;
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: write, read, fairness with stall,
// bad component id, read timeout (REG_BUS_TIMEOUT_EN) or unbounded wait,
// and reset in the middle of a read.
module tb_reg_bus_arbiter;
    import reg_bus_arbiter_pkg::*;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic [1:0]               req_valid;
    logic [1:0]               req_ready;
    reg_bus_req_t [1:0]       req;
    logic [1:0]               resp_valid;
    logic [1:0]               resp_ready;
    reg_data_t                resp_data;
    logic                     resp_err;
    logic [15:0]              waddr;
    reg_data_t                wdata;
    logic [ID_LAST-1:0]       wvalid;
    logic [ID_LAST-1:0]       arvalid;
    logic [15:0]              araddr;
    logic [ID_LAST-1:0]       rvalid;
    reg_data_t [ID_LAST-1:0]  rdata;

    int total = 0;
    int bad   = 0;

    reg_bus_arbiter #(
        .N_REQ          (2),
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req             (req),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_err        (resp_err),
        .reg_bus_waddr   (waddr),
        .reg_bus_wdata   (wdata),
        .reg_bus_wvalid  (wvalid),
        .reg_bus_arvalid (arvalid),
        .reg_bus_araddr  (araddr),
        .reg_bus_rvalid  (rvalid),
        .reg_bus_rdata   (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Move to just after the next falling edge; inputs change and outputs are sampled here.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [7:0] c,
                           input logic [7:0] a, input reg_data_t d);
        req[i] = '{write: w, comp: c, addr: a, wdata: d};
    endtask

    function automatic logic [143:0] all_outputs();
        return {req_ready, resp_valid, resp_data, resp_err, waddr, wdata, wvalid, arvalid, araddr, 1'b0};
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        req_valid = '0; resp_ready = '0; rvalid = '0; rdata = '0; req = '0;
        step();
        step();
        total++; if (all_outputs() !== '0) begin bad++; $display("FAIL reset_outputs: got %h expected 0", all_outputs()); end
        rstn = 1'b1;
        step();
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid: got %b expected 00", resp_valid); end
    endtask

    task automatic test_write();
        step();
        set_req(0, 1'b1, 8'd3, 8'h10, 32'hA5A5_0001);
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL wr_ready: got %b expected 01", req_ready); end
        step(); // t+1
        req_valid = '0;
        total++; if (wvalid !== 8'h08) begin bad++; $display("FAIL wr_wvalid: got %h expected 08", wvalid); end
        total++; if (waddr !== 16'h0010) begin bad++; $display("FAIL wr_waddr: got %h expected 0010", waddr); end
        total++; if (wdata !== 32'hA5A5_0001) begin bad++; $display("FAIL wr_wdata: got %h expected a5a50001", wdata); end
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL wr_resp_early: got %b expected 00", resp_valid); end
        step(); // t+2
        total++; if (wvalid !== 8'h00) begin bad++; $display("FAIL wr_wvalid_once: got %h expected 00", wvalid); end
        total++; if (waddr !== 16'h0010) begin bad++; $display("FAIL wr_waddr_hold: got %h expected 0010", waddr); end
        total++; if (resp_valid !== 2'b01) begin bad++; $display("FAIL wr_resp_valid: got %b expected 01", resp_valid); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL wr_resp_err: got %b expected 0", resp_err); end
        total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL wr_resp_data: got %h expected 0", resp_data); end
        resp_ready = 2'b01;
        step();
        resp_ready = '0;
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL wr_resp_drop: got %b expected 00", resp_valid); end
    endtask

    task automatic test_read();
        step(); // t
        set_req(1, 1'b0, 8'd2, 8'h04, 32'h0);
        req_valid = 2'b10;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rd_ready: got %b expected 10", req_ready); end
        step(); // t+1
        req_valid = '0;
        total++; if (arvalid !== 8'h04) begin bad++; $display("FAIL rd_arvalid: got %h expected 04", arvalid); end
        total++; if (araddr !== 16'h0004) begin bad++; $display("FAIL rd_araddr: got %h expected 0004", araddr); end
        total++; if (wvalid !== 8'h00) begin bad++; $display("FAIL rd_no_wvalid: got %h expected 00", wvalid); end
        step(); // t+2
        total++; if (arvalid !== 8'h00) begin bad++; $display("FAIL rd_arvalid_once: got %h expected 00", arvalid); end
        step(); // t+3: a different component returns data, must be ignored
        rvalid = 8'h20; rdata[5] = 32'h0000_0BAD;
        step(); // t+4
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL rd_other_comp_ignored: got %b expected 00", resp_valid); end
        rvalid = 8'h04; rdata[2] = 32'h0000_1234;
        step(); // t+5
        rvalid = '0;
        total++; if (resp_valid !== 2'b10) begin bad++; $display("FAIL rd_resp_valid: got %b expected 10", resp_valid); end
        total++; if (resp_data !== 32'h0000_1234) begin bad++; $display("FAIL rd_resp_data: got %h expected 00001234", resp_data); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rd_resp_err: got %b expected 0", resp_err); end
        total++; if (araddr !== 16'h0004) begin bad++; $display("FAIL rd_araddr_hold: got %h expected 0004", araddr); end
        resp_ready = 2'b10;
        step();
        resp_ready = '0;
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL rd_resp_drop: got %b expected 00", resp_valid); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp;
        step();
        set_req(0, 1'b1, 8'd1, 8'h20, 32'h0000_00A0);
        set_req(1, 1'b1, 8'd1, 8'h21, 32'h0000_00A1);
        req_valid = 2'b11;
        for (int n = 0; n < 6; n++) begin
            exp = (n % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            total++; if (req_ready !== exp) begin bad++; $display("FAIL fair_grant%0d: got %b expected %b", n, req_ready, exp); end
            step(); // WR
            total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL fair_busy%0d: got %b expected 00", n, req_ready); end
            step(); // RESP
            total++; if (resp_valid !== exp) begin bad++; $display("FAIL fair_resp%0d: got %b expected %b", n, resp_valid, exp); end
            if (n == 0) begin
                for (int s = 0; s < 5; s++) begin
                    step();
                    total++; if ({resp_valid, req_ready} !== {exp, 2'b00}) begin
                        bad++; $display("FAIL fair_stall%0d: got %b/%b expected %b/00", s, resp_valid, req_ready, exp);
                    end
                end
            end
            resp_ready = exp;
            step(); // back in IDLE
            resp_ready = '0;
            if (n == 5) req_valid = '0;
        end
    endtask

    task automatic test_bad_id();
        logic [1:0] who;
        for (int i = 0; i < 2; i++) begin
            who = (i == 0) ? 2'b01 : 2'b10;
            step();
            if (i == 0) set_req(0, 1'b1, 8'd8, 8'h40, 32'h1111_2222);
            else        set_req(1, 1'b0, 8'hFF, 8'h41, 32'h0);
            req_valid = who;
            #1;
            total++; if (req_ready !== who) begin bad++; $display("FAIL bad_ready%0d: got %b expected %b", i, req_ready, who); end
            step(); // t+1
            req_valid = '0;
            total++; if (resp_valid !== who) begin bad++; $display("FAIL bad_resp%0d: got %b expected %b", i, resp_valid, who); end
            total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL bad_err%0d: got %b expected 1", i, resp_err); end
            total++; if (resp_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bad_data%0d: got %h expected deadbeef", i, resp_data); end
            total++; if ({wvalid, arvalid} !== 16'h0) begin bad++; $display("FAIL bad_no_strobe%0d: got %h expected 0000", i, {wvalid, arvalid}); end
            resp_ready = who;
            step();
            resp_ready = '0;
            total++; if ({wvalid, arvalid, resp_valid} !== 18'h0) begin bad++; $display("FAIL bad_after%0d: got %h expected 0", i, {wvalid, arvalid, resp_valid}); end
        end
    endtask

`ifdef REG_BUS_TIMEOUT_EN
    task automatic test_timeout();
        for (int c = 0; c < 2; c++) begin
            step(); // t
            set_req(0, 1'b0, 8'd1, 8'h30, 32'h0);
            req_valid = 2'b01;
            step(); // t+1
            req_valid = '0;
            total++; if (arvalid !== 8'h02) begin bad++; $display("FAIL tmo_arvalid%0d: got %h expected 02", c, arvalid); end
            for (int w = 0; w < 8; w++) begin
                step(); // t+2 .. t+9
                total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL tmo_wait%0d_%0d: got %b expected 00", c, w, resp_valid); end
            end
            if (c == 1) begin
                rvalid = 8'h02; rdata[1] = 32'h6789_ABCD;
            end
            step(); // t+10
            rvalid = '0;
            total++; if (resp_valid !== 2'b01) begin bad++; $display("FAIL tmo_resp%0d: got %b expected 01", c, resp_valid); end
            if (c == 0) begin
                total++; if ({resp_err, resp_data} !== {1'b1, 32'hDEAD_BEEF}) begin bad++; $display("FAIL tmo_expire: got %b/%h expected 1/deadbeef", resp_err, resp_data); end
                rvalid = 8'h02; rdata[1] = 32'h0000_5555;
                step();
                rvalid = '0;
                total++; if ({resp_valid, resp_err, resp_data} !== {2'b01, 1'b1, 32'hDEAD_BEEF}) begin
                    bad++; $display("FAIL tmo_late_ignored: got %b/%b/%h expected 01/1/deadbeef", resp_valid, resp_err, resp_data);
                end
            end else begin
                total++; if ({resp_err, resp_data} !== {1'b0, 32'h6789_ABCD}) begin bad++; $display("FAIL tmo_rvalid_wins: got %b/%h expected 0/6789abcd", resp_err, resp_data); end
            end
            resp_ready = 2'b01;
            step();
            resp_ready = '0;
            total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL tmo_done%0d: got %b expected 00", c, resp_valid); end
        end
    endtask
`else
    task automatic test_no_timeout();
        int early;
        early = 0;
        step();
        set_req(0, 1'b0, 8'd1, 8'h30, 32'h0);
        req_valid = 2'b01;
        step();
        req_valid = '0;
        for (int w = 0; w < 20; w++) begin
            step();
            if (resp_valid !== 2'b00) early++;
        end
        total++; if (early !== 0) begin bad++; $display("FAIL wait_forever: got %0d early responses expected 0", early); end
        rvalid = 8'h02; rdata[1] = 32'h0BAD_F00D;
        step();
        rvalid = '0;
        total++; if ({resp_valid, resp_err, resp_data} !== {2'b01, 1'b0, 32'h0BAD_F00D}) begin
            bad++; $display("FAIL wait_data: got %b/%b/%h expected 01/0/0badf00d", resp_valid, resp_err, resp_data);
        end
        resp_ready = 2'b01;
        step();
        resp_ready = '0;
    endtask
`endif

    task automatic test_reset_mid();
        step(); // t: req0 read, pointer moves to 1
        set_req(0, 1'b0, 8'd0, 8'h08, 32'h0);
        req_valid = 2'b01;
        step(); // AR
        req_valid = '0;
        step(); // RWAIT
        rstn = 1'b0;
        #1;
        total++; if (all_outputs() !== '0) begin bad++; $display("FAIL mid_reset_outputs: got %h expected 0", all_outputs()); end
        step();
        rstn = 1'b1;
        step();
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL mid_no_resp: got %b expected 00", resp_valid); end
        set_req(0, 1'b0, 8'd0, 8'h0C, 32'h0);
        set_req(1, 1'b1, 8'd1, 8'h0D, 32'h0000_0077);
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL mid_ptr_zero: got %b expected 01", req_ready); end
        step(); // t+1
        req_valid = '0;
        total++; if ({arvalid, araddr} !== {8'h01, 16'h000C}) begin bad++; $display("FAIL mid_arvalid: got %h/%h expected 01/000c", arvalid, araddr); end
        step(); // t+2
        rvalid = 8'h01; rdata[0] = 32'hCAFE_0006;
        step(); // t+3
        rvalid = '0;
        total++; if ({resp_valid, resp_err, resp_data} !== {2'b01, 1'b0, 32'hCAFE_0006}) begin
            bad++; $display("FAIL mid_read: got %b/%b/%h expected 01/0/cafe0006", resp_valid, resp_err, resp_data);
        end
        resp_ready = 2'b01;
        step();
        resp_ready = '0;
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL mid_done: got %b expected 00", resp_valid); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fairness();
        test_bad_id();
`ifdef REG_BUS_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
